// File: rtl/router_pkg.sv
// rtl/router_pkg.sv - shared router types: FSM states, port direction type and direction codes
package router_pkg;

    localparam int ROUTER_PORTS = 4;
    localparam int DIR_BITS     = $clog2(ROUTER_PORTS);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_e;

    typedef logic [DIR_BITS-1:0] port_dir_t;

    localparam port_dir_t NORTH = 2'd0;
    localparam port_dir_t SOUTH = 2'd1;
    localparam port_dir_t EAST  = 2'd2;
    localparam port_dir_t WEST  = 2'd3;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter using a double-width masked scan
module rr_arbiter #(
    parameter  int N        = 4,
    localparam int IDX_BITS = $clog2(N)
) (
    input  logic [N-1:0]        req,
    input  logic [IDX_BITS-1:0] ptr,
    output logic [IDX_BITS-1:0] gnt_idx,
    output logic                any_gnt
);

    // Two copies of the request vector back to back; masking off everything
    // below ptr in the doubled vector turns a circular search into a linear one.
    logic [2*N-1:0] dbl_req;
    logic [2*N-1:0] masked;

    // Build the doubled request vector and drop the positions before the pointer
    always_comb begin
        dbl_req = {req, req};
        masked  = '0;
        for (int j = 0; j < 2*N; j++) begin
            masked[j] = dbl_req[j] && (j >= int'(ptr));
        end
    end

    // Lowest set bit of the masked vector wins; scan downward so the last hit is the lowest
    always_comb begin
        gnt_idx = '0;
        any_gnt = 1'b0;
        for (int j = 2*N-1; j >= 0; j--) begin
            if (masked[j]) begin
                any_gnt = 1'b1;
                gnt_idx = (j >= N) ? IDX_BITS'(j - N) : IDX_BITS'(j);
            end
        end
    end

endmodule

// File: rtl/vc_select_rr.sv
// rtl/vc_select_rr.sv - per-output-port VC selector with round-robin fairness and packet locking
module vc_select_rr
    import router_pkg::*;
#(
    parameter  int NUM_VC    = 4,
    parameter  int NUM_PORTS = 4,
    localparam int PORT_BITS = $clog2(NUM_PORTS),
    localparam int VC_BITS   = $clog2(NUM_VC)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_VC-1:0]    vc_valid,
    input  logic [PORT_BITS-1:0] vc_direction [NUM_VC],
    input  logic [PORT_BITS-1:0] sel_direction,
    input  logic                 req_valid,
    input  logic                 pkt_release,
    output logic                 gnt_valid,
    output logic [VC_BITS-1:0]   vc_index,
    output logic                 locked
);

    state_e              state;
    state_e              state_next;
    logic                grant_fire;
    logic [NUM_VC-1:0]   cand;
    logic [VC_BITS-1:0]  rr_ptr;
    logic [VC_BITS-1:0]  arb_idx;
    logic                arb_any;
    logic [VC_BITS-1:0]  ptr_after;

    // A VC is a candidate when it holds a head flit routed to this output
    always_comb begin
        cand = '0;
        for (int i = 0; i < NUM_VC; i++) begin
            cand[i] = vc_valid[i] && (vc_direction[i] == sel_direction);
        end
    end

    rr_arbiter #(
        .N (NUM_VC)
    ) u_arb (
        .req     (cand),
        .ptr     (rr_ptr),
        .gnt_idx (arb_idx),
        .any_gnt (arb_any)
    );

    // Pointer moves one past the winner, wrapping explicitly so non-power-of-2 counts work
    always_comb begin
        ptr_after = '0;
        if (arb_idx != VC_BITS'(NUM_VC - 1)) begin
            ptr_after = arb_idx + VC_BITS'(1);
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: grant from IDLE, hold while LOCKED until the tail departs
    always_comb begin
        state_next = state;
        grant_fire = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid && arb_any) begin
                    state_next = LOCKED;
                    grant_fire = 1'b1;
                end
            end
            LOCKED: begin
                if (pkt_release) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Registered outputs and fairness pointer; vc_index keeps its value after release
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr    <= '0;
            vc_index  <= '0;
            gnt_valid <= 1'b0;
            locked    <= 1'b0;
        end else begin
            gnt_valid <= grant_fire;
            locked    <= (state_next == LOCKED);
            if (grant_fire) begin
                vc_index <= arb_idx;
                rr_ptr   <= ptr_after;
            end
        end
    end

endmodule

// File: tb/tb_vc_select_rr.sv
// tb/tb_vc_select_rr.sv - randomized and directed self-checking bench for vc_select_rr
module tb_vc_select_rr;
    import router_pkg::*;

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    always #5 clk = ~clk;

    logic [3:0] vc_valid;
    logic [1:0] vc_direction [4];
    logic [1:0] sel_direction;
    logic       req_valid;
    logic       pkt_release;
    logic       gnt_valid;
    logic [1:0] vc_index;
    logic       locked;

    logic [2:0] v3;
    logic [1:0] d3 [3];
    logic [1:0] sel3;
    logic       req3;
    logic       rel3;
    logic       gnt3;
    logic [1:0] idx3;
    logic       lck3;

    int errors = 0;
    int checks = 0;

    vc_select_rr #(.NUM_VC(4), .NUM_PORTS(4)) dut (
        .clk(clk), .reset(reset), .vc_valid(vc_valid), .vc_direction(vc_direction),
        .sel_direction(sel_direction), .req_valid(req_valid), .pkt_release(pkt_release),
        .gnt_valid(gnt_valid), .vc_index(vc_index), .locked(locked)
    );

    vc_select_rr #(.NUM_VC(3), .NUM_PORTS(4)) dut3 (
        .clk(clk), .reset(reset), .vc_valid(v3), .vc_direction(d3),
        .sel_direction(sel3), .req_valid(req3), .pkt_release(rel3),
        .gnt_valid(gnt3), .vc_index(idx3), .locked(lck3)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a packet owner plus a "next VC to favour" pointer
    int m_busy   = 0;
    int m_ptr    = 0;
    int m_idx    = 0;
    int m_gnt    = 0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_busy = 0; m_ptr = 0; m_idx = 0; m_gnt = 0;
        end else begin
            m_gnt = 0;
            if (m_busy == 0) begin
                if (req_valid) begin
                    for (int k = 0; k < 4; k++) begin
                        int c;
                        c = (m_ptr + k) % 4;
                        if (m_gnt == 0 && vc_valid[c] && vc_direction[c] == sel_direction) begin
                            m_idx  = c;
                            m_gnt  = 1;
                            m_busy = 1;
                            m_ptr  = (c + 1) % 4;
                        end
                    end
                end
            end else if (pkt_release) begin
                m_busy = 0;
            end
        end
    end

    // Every cycle: DUT outputs must match the model
    always @(negedge clk) begin
        chk("cmp_gnt_valid", gnt_valid, m_gnt);
        chk("cmp_vc_index", vc_index, m_idx);
        chk("cmp_locked", locked, m_busy);
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    initial begin
        vc_valid = '0; sel_direction = '0; req_valid = 0; pkt_release = 0;
        for (int i = 0; i < 4; i++) vc_direction[i] = '0;
        v3 = '0; sel3 = '0; req3 = 0; rel3 = 0;
        for (int i = 0; i < 3; i++) d3[i] = '0;

        repeat (2) cyc();
        chk("reset_gnt", gnt_valid, 0);
        chk("reset_idx", vc_index, 0);
        chk("reset_locked", locked, 0);
        reset = 1;

        // Candidate selection: only VC2/VC3 route to EAST
        vc_direction[0] = NORTH; vc_direction[1] = NORTH;
        vc_direction[2] = EAST;  vc_direction[3] = EAST;
        sel_direction = EAST; vc_valid = 4'b1111; req_valid = 1;
        cyc();
        chk("cand_gnt", gnt_valid, 1);
        chk("cand_idx", vc_index, 2);
        chk("cand_locked", locked, 1);
        chk("model_pin_idx", m_idx, 2);
        chk("model_pin_ptr", m_ptr, 3);
        req_valid = 0;
        cyc();
        chk("cand_pulse", gnt_valid, 0);
        chk("cand_hold", locked, 1);
        pkt_release = 1;
        cyc();
        chk("cand_release", locked, 0);
        pkt_release = 0;

        // Wrap-around: pointer at 3, only VC0/VC1 candidates
        vc_valid = 4'b0011;
        vc_direction[0] = EAST; vc_direction[1] = EAST;
        req_valid = 1;
        cyc();
        chk("wrap_idx", vc_index, 0);
        chk("wrap_gnt", gnt_valid, 1);
        req_valid = 0; pkt_release = 1;
        cyc();
        pkt_release = 0; req_valid = 1;
        cyc();
        chk("wrap_next_idx", vc_index, 1);

        // Lock hold on VC1 while its request disappears and VC3 appears
        vc_valid = 4'b1000;
        for (int r = 0; r < 4; r++) begin
            req_valid = ~req_valid;
            if (r == 2) sel_direction = SOUTH;
            cyc();
            chk("hold_idx", vc_index, 1);
            chk("hold_gnt", gnt_valid, 0);
            chk("hold_locked", locked, 1);
        end
        sel_direction = EAST;
        pkt_release = 1;
        cyc();
        pkt_release = 0;
        chk("hold_release", locked, 0);

        // Async reset mid-packet: lock and pointer cleared at once
        vc_valid = 4'b1111;
        req_valid = 1;
        cyc();
        chk("pre_reset_locked", locked, 1);
        #2 reset = 0;
        #1;
        chk("async_gnt", gnt_valid, 0);
        chk("async_locked", locked, 0);
        chk("async_idx", vc_index, 0);
        cyc();
        reset = 1;

        // Fairness: all four VCs to SOUTH, each packet held 3 cycles
        for (int i = 0; i < 4; i++) vc_direction[i] = SOUTH;
        sel_direction = SOUTH;
        for (int e = 0; e < 5; e++) begin
            cyc();
            chk("fair_gnt", gnt_valid, 1);
            chk("fair_idx", vc_index, e % 4);
            repeat (2) begin
                cyc();
                chk("fair_hold", locked, 1);
            end
            pkt_release = 1;
            cyc();
            pkt_release = 0;
            chk("fair_bubble_locked", locked, 0);
            chk("fair_bubble_gnt", gnt_valid, 0);
        end

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            vc_valid = 4'($urandom);
            for (int i = 0; i < 4; i++) vc_direction[i] = 2'($urandom);
            if ($urandom_range(15) == 0) sel_direction = 2'($urandom);
            req_valid   = ($urandom_range(3) != 0);
            pkt_release = ($urandom_range(2) == 0);
            cyc();
        end
        req_valid = 0; pkt_release = 1;
        cyc();
        pkt_release = 0;

        // Three-VC instance: no-op inputs and pointer wrap
        rel3 = 1;
        cyc();
        chk("nv3_rel_idle_gnt", gnt3, 0);
        chk("nv3_rel_idle_lck", lck3, 0);
        rel3 = 0; v3 = 3'b111; sel3 = 2'd1; req3 = 1;
        repeat (2) cyc();
        chk("nv3_nocand_gnt", gnt3, 0);
        chk("nv3_nocand_lck", lck3, 0);
        d3[2] = 2'd1;
        cyc();
        chk("nv3_vc2_gnt", gnt3, 1);
        chk("nv3_vc2_idx", idx3, 2);
        req3 = 0; rel3 = 1;
        cyc();
        rel3 = 0;
        chk("nv3_release", lck3, 0);
        d3[0] = 2'd1; d3[1] = 2'd1; req3 = 1;
        cyc();
        chk("nv3_wrap_idx", idx3, 0);
        chk("nv3_wrap_gnt", gnt3, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
